// File: rtl/comparator_seq_n_if.sv
// Request/response bundle for the chunk-serial magnitude comparator.
// master drives operands, cascade bits and start; slave returns status and result.
interface comparator_seq_n_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gt_in;
  logic             lt_in;
  logic             eq_in;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
    output start, a, b, gt_in, lt_in, eq_in, signed_mode,
    input  busy, done, gt, lt, eq
  );

  modport slave (
    input  start, a, b, gt_in, lt_in, eq_in, signed_mode,
    output busy, done, gt, lt, eq
  );
endinterface

// File: rtl/comparator_seq_n.sv
// Chunk-serial comparator: walks WIDTH/CHUNK slices MSB-first, one per cycle.
// The first unequal slice decides gt/lt; if all slices match, the latched
// cascade bits are passed through.
// Optional macro COMPARATOR_SEQ_EARLY_EXIT_EN: finish on the deciding slice
// instead of always spending N cycles (constant-time when undefined).
module comparator_seq_n #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic               clk,
  input logic               rst_n,
  comparator_seq_n_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Snapshot of one request; operands shift left so the live slice is always on top.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gt_in;
    logic             lt_in;
    logic             eq_in;
    logic             sgn;
  } req_t;

  state_t          state;
  req_t            req;
  logic [IW-1:0]   idx;
  logic            decided, dgt, dlt;
  logic            busy_q, done_q, gt_q, lt_q, eq_q;

  logic [CHUNK-1:0] sa, sb;
  logic             s_gt, s_lt, s_ne, last, fin;

  // Current slice compare; the top slice in signed mode flips its sign bit so
  // an unsigned compare gives two's-complement ordering.
  always_comb begin
    sa = req.a[WIDTH-1 -: CHUNK];
    sb = req.b[WIDTH-1 -: CHUNK];
    if (req.sgn && (idx == '0)) begin
      sa[CHUNK-1] = ~sa[CHUNK-1];
      sb[CHUNK-1] = ~sb[CHUNK-1];
    end
    s_gt = (sa > sb);
    s_lt = (sa < sb);
    s_ne = s_gt | s_lt;
    last = (idx == LAST);
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    fin  = last | (~decided & s_ne);
`else
    fin  = last;
`endif
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      dgt     <= 1'b0;
      dlt     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            req.a     <= bus.a;
            req.b     <= bus.b;
            req.gt_in <= bus.gt_in;
            req.lt_in <= bus.lt_in;
            req.eq_in <= bus.eq_in;
            req.sgn   <= bus.signed_mode;
            idx       <= '0;
            decided   <= 1'b0;
            dgt       <= 1'b0;
            dlt       <= 1'b0;
            busy_q    <= 1'b1;
            state     <= RUN;
          end else begin
            state     <= IDLE;
          end
        end
        RUN: begin
          // Freeze the verdict at the first unequal slice; later slices are don't-care.
          if (!decided && s_ne) begin
            decided <= 1'b1;
            dgt     <= s_gt;
            dlt     <= s_lt;
          end
          if (fin) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
            if (decided) begin
              gt_q <= dgt;
              lt_q <= dlt;
              eq_q <= 1'b0;
            end else if (s_ne) begin
              gt_q <= s_gt;
              lt_q <= s_lt;
              eq_q <= 1'b0;
            end else begin
              gt_q <= req.gt_in;
              lt_q <= req.lt_in;
              eq_q <= req.eq_in;
            end
          end else begin
            idx   <= idx + IW'(1);
            req.a <= req.a << CHUNK;
            req.b <= req.b << CHUNK;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
endmodule

// File: tb/tb_comparator_seq_n.sv
// Bench for comparator_seq_n at WIDTH=16, CHUNK=4: vector table, random
// vectors against a whole-word reference, and hand sequences for mid-run
// start, back-to-back, and mid-run reset. Results are checked via a queue.
module tb_comparator_seq_n;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        gi;
    logic        li;
    logic        ei;
    logic        sm;
    logic [2:0]  res;  // {gt,lt,eq}
    int          le;   // latency with early exit
  } vec_t;

  typedef struct {
    logic [2:0] res;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  vec_t tbl[12];

  comparator_seq_n_if #(.WIDTH(WIDTH)) bus ();

  comparator_seq_n #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int lat(input vec_t v);
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    return v.le;
`else
    return N;
`endif
  endfunction

  // Reference built from whole-word compares, independent of slicing.
  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic gi, input logic li, input logic ei, input logic sm);
    vec_t v;
    v.a = a; v.b = b; v.gi = gi; v.li = li; v.ei = ei; v.sm = sm;
    if (a == b)       v.res = {gi, li, ei};
    else if (sm)      v.res = ($signed(a) > $signed(b)) ? 3'b100 : 3'b010;
    else              v.res = (a > b) ? 3'b100 : 3'b010;
    v.le = N;
    for (int k = N - 1; k >= 0; k--)
      if (a[15-4*k -: 4] != b[15-4*k -: 4]) v.le = k + 1;
    return v;
  endfunction

  // Drive one request at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input vec_t v);
    exp_t e;
    bus.a = v.a; bus.b = v.b;
    bus.gt_in = v.gi; bus.lt_in = v.li; bus.eq_in = v.ei;
    bus.signed_mode = v.sm;
    bus.start = 1'b1;
    e.res = v.res;
    e.t   = cyc + 1 + lat(v);
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    exp_t e;
    int n = 0;
    while (bus.done !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout done never seen", nm);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_unexpected done with empty queue", nm);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("%s_res", nm), {29'd0, bus.gt, bus.lt, bus.eq}, {29'd0, e.res});
      chk($sformatf("%s_cycle", nm), cyc, e.t);
    end
  endtask

  initial begin
    int seen;
    vec_t v;
    bus.start = 0; bus.a = '0; bus.b = '0;
    bus.gt_in = 0; bus.lt_in = 0; bus.eq_in = 0; bus.signed_mode = 0;

    tbl[0]  = '{16'h1234, 16'h1234, 1, 0, 0, 0, 3'b100, 4};
    tbl[1]  = '{16'h8000, 16'h7FFF, 0, 0, 1, 0, 3'b100, 1};
    tbl[2]  = '{16'h8000, 16'h7FFF, 0, 0, 1, 1, 3'b010, 1};
    tbl[3]  = '{16'hA000, 16'h1000, 0, 0, 1, 0, 3'b100, 1};
    tbl[4]  = '{16'h1234, 16'h1235, 0, 0, 1, 0, 3'b010, 4};
    tbl[5]  = '{16'h00F0, 16'h0010, 0, 0, 1, 0, 3'b100, 3};
    tbl[6]  = '{16'hFFFF, 16'hFFFF, 0, 0, 1, 1, 3'b001, 4};
    tbl[7]  = '{16'hFFFF, 16'h0001, 0, 0, 1, 1, 3'b010, 1};
    tbl[8]  = '{16'h0000, 16'hFFFF, 1, 0, 0, 0, 3'b010, 1};
    tbl[9]  = '{16'h5555, 16'h5555, 0, 1, 0, 0, 3'b010, 4};
    tbl[10] = '{16'h7000, 16'h7100, 0, 0, 1, 1, 3'b010, 2};
    tbl[11] = '{16'h8000, 16'h8001, 0, 0, 1, 1, 3'b010, 4};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, bus.busy, bus.done, bus.gt, bus.lt, bus.eq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      issue(tbl[i]);
      chk($sformatf("tbl%0d_busy", i), {31'd0, bus.busy}, 32'd1);
      wait_done($sformatf("tbl%0d", i));
      @(negedge clk);
      chk($sformatf("tbl%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      v = mk(16'($urandom), (i % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 15)),
             1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if (i == 3) v = mk(v.a, v.a, 1'b0, 1'b1, 1'b0, 1'b1);
      issue(v);
      wait_done($sformatf("rnd%0d", i));
      @(negedge clk);
    end

    // Start re-pulse and operand change in the middle of a run.
    issue(mk(16'h1235, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("midrun");
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("midrun_single_done", seen, 0);

    // Back-to-back: start held while DONE.
    issue(mk(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0));
    wait_done("b2b_first");
    issue(mk(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0));
    chk("b2b_no_idle", {30'd0, bus.busy, bus.done}, 32'd2);
    wait_done("b2b_second");
    @(negedge clk);

    // Reset in the middle of a run; gt is 1 from the previous... eq is 1 here.
    bus.a = 16'h1235; bus.b = 16'h1234;
    bus.gt_in = 0; bus.lt_in = 0; bus.eq_in = 1; bus.signed_mode = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_midrun_outputs", {27'd0, bus.busy, bus.done, bus.gt, bus.lt, bus.eq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("rst_no_done", seen, 0);

    chk("queue_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/comparator_seq_n.md
COMPARATOR_SEQ_N -- requirements
Module: comparator_seq_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits compared per cycle; WIDTH%CHUNK==0, CHUNK>=1, CHUNK<=WIDTH; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request a comparison.
REQ-006 SHALL have ports a and b, input, WIDTH: operands.
REQ-007 SHALL have ports gt_in, lt_in and eq_in, input, 1 each: cascade inputs from a less-significant stage.
REQ-008 SHALL have port signed_mode, input, 1: 1 selects two's-complement compare, 0 selects unsigned.
REQ-009 SHALL have port busy, output, 1: comparison in progress.
REQ-010 SHALL have port done, output, 1: one-cycle result-valid pulse.
REQ-011 SHALL have ports gt, lt and eq, output, 1 each: registered result.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; reset state IDLE.
REQ-013 SHALL accept start only in IDLE or DONE, latching a, b, gt_in, lt_in, eq_in and signed_mode on that edge and entering RUN with chunk index 0 (MSB chunk).
REQ-014 SHALL ignore start while in RUN; operand or cascade changes during RUN SHALL NOT affect the result.
REQ-015 SHALL compare one CHUNK-bit slice per cycle in RUN, MSB slice first; the first unequal slice decides the result.
REQ-016 SHALL, in signed mode, treat the MSB of the top slice as inverted for ordering; all lower slices SHALL compare unsigned.
REQ-017 SHALL, when all slices are equal, output gt/lt/eq = the latched gt_in/lt_in/eq_in.
REQ-018 SHALL, in the default (non-early-exit) build, keep busy=1 for exactly N cycles after the accepting edge, then on edge T0+N clear busy, set done=1, update gt/lt/eq and enter DONE.
REQ-019 SHALL hold done=1 for exactly one cycle; DONE SHALL go to IDLE, or to RUN if start is high.
REQ-020 SHALL hold gt/lt/eq stable from the done edge until the next done edge; at most one of gt/lt SHALL be 1 for a decided inequality.
REQ-021 SHALL assert busy only in RUN and done only in DONE.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-RUN, immediately force IDLE with busy=0, done=0, gt=0, lt=0 and eq=0; the aborted comparison SHALL produce no done.
REQ-023 SHALL clear the slice index and latched operands to 0 on reset.
REQ-024 SHALL take no action on start until the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL support macro COMPARATOR_SEQ_EARLY_EXIT_EN.
  - Defined: when slice j (0 = MSB) is the first unequal slice, finish on edge T0+j+1 (busy clear, done pulse, result update); equal operands still take N cycles.
  - Undefined: always N cycles (constant time), with the result frozen at the first unequal slice.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-026 SHALL cover equal operands: a=b=0x1234, gt_in=1, lt_in=0, eq_in=0 -> done at T0+4 with gt=1, lt=0, eq=0.
REQ-027 SHALL cover signedness: a=0x8000, b=0x7FFF, signed_mode=0 -> gt=1; same operands with signed_mode=1 -> lt=1.
REQ-028 SHALL cover early exit: a=0xA000, b=0x1000 -> gt=1 and done at T0+1 with COMPARATOR_SEQ_EARLY_EXIT_EN, at T0+4 without it.
REQ-029 SHALL cover start during RUN and input changes mid-run: start re-pulsed and a changed to 0x0000 at T0+2 -> original result, a single done at T0+4.
REQ-030 SHALL cover reset mid-run: rst_n low at T0+2 -> busy, done, gt, lt and eq all 0 at once, and no done after rst_n releases.
REQ-031 SHALL cover back-to-back operation: start held high in DONE -> a new RUN begins with no IDLE cycle, next done 4 cycles later.
